// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered grant index, its one-hot
// decode, and an optional per-owner hold limit.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       gnt_new
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nx;
    logic [2:0]        ptr, ptr_nx, idx_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic              new_nx;
    logic              release_now;

    // First requester found scanning upward from start, wrapping modulo 8.
    function automatic logic [2:0] win(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] c;
        logic       hit;
        win = start;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c = start + 3'(i);
            if (!hit && r[c]) begin
                win = c;
                hit = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        idx_nx      = gnt_idx;
        hold_nx     = hold_cnt;
        new_nx      = 1'b0;
        release_now = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = BUSY;
                    idx_nx   = win(req, ptr);
                    hold_nx  = '0;
                    new_nx   = 1'b1;
                end
            end
            BUSY: begin
                release_now = !req[gnt_idx] || ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST));
                if (hold_cnt != '1) begin
                    hold_nx = hold_cnt + 1'b1;
                end
                if (release_now) begin
                    // The outgoing owner is scanned last, so a timed-out sole
                    // requester gets re-granted with a fresh hold count.
                    ptr_nx = gnt_idx + 3'd1;
                    if (|req) begin
                        idx_nx  = win(req, gnt_idx + 3'd1);
                        hold_nx = '0;
                        new_nx  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        hold_nx  = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_new   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= (state_nx == BUSY);
            gnt       <= (state_nx == BUSY) ? (8'h01 << idx_nx) : 8'h00;
            gnt_new   <= new_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: four instances with different hold limits
// share clock, reset and request stimulus.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;

    logic [7:0] g16, g4, g3, g0;
    logic [2:0] i16, i4, i3, i0;
    logic       v16, v4, v3, v0;
    logic       n16, n4, n3, n0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(16), .HOLD_W(8)) u_h16 (
        .clk(clk), .rst(rst), .req(req), .gnt(g16), .gnt_idx(i16), .gnt_valid(v16), .gnt_new(n16));
    rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) u_h4 (
        .clk(clk), .rst(rst), .req(req), .gnt(g4), .gnt_idx(i4), .gnt_valid(v4), .gnt_new(n4));
    rr_arbiter8 #(.MAX_HOLD(3), .HOLD_W(8)) u_h3 (
        .clk(clk), .rst(rst), .req(req), .gnt(g3), .gnt_idx(i3), .gnt_valid(v3), .gnt_new(n3));
    rr_arbiter8 #(.MAX_HOLD(0), .HOLD_W(8)) u_h0 (
        .clk(clk), .rst(rst), .req(req), .gnt(g0), .gnt_idx(i0), .gnt_valid(v0), .gnt_new(n0));

    // Advance one clock; outputs are then stable until the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hFF;
        step();
        step();
        checks++;
        if (g16 !== 8'h00) begin failures++; $display("FAIL reset_gnt got=%h exp=00", g16); end
        checks++;
        if (v16 !== 1'b0 || n16 !== 1'b0 || i16 !== 3'd0) begin
            failures++; $display("FAIL reset_ctl got v=%b n=%b i=%0d exp v=0 n=0 i=0", v16, n16, i16);
        end
        rst = 1'b0;
        step();
        checks++;
        if (g16 !== 8'h01 || n16 !== 1'b1 || v16 !== 1'b1) begin
            failures++; $display("FAIL first_grant got gnt=%h n=%b v=%b exp gnt=01 n=1 v=1", g16, n16, v16);
        end
        step();
        checks++;
        if (g16 !== 8'h01 || n16 !== 1'b0) begin
            failures++; $display("FAIL first_hold got gnt=%h n=%b exp gnt=01 n=0", g16, n16);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_idx;
        do_reset();
        req = 8'hFF;
        step();
        for (int o = 0; o < 9; o++) begin
            exp_idx = 3'(o % 8);
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (i4 !== exp_idx || g4 !== (8'h01 << exp_idx) || v4 !== 1'b1 || n4 !== (c == 0)) begin
                    failures++;
                    $display("FAIL rotation o=%0d c=%0d got i=%0d gnt=%h v=%b n=%b exp i=%0d gnt=%h v=1 n=%0d",
                             o, c, i4, g4, v4, n4, exp_idx, 8'h01 << exp_idx, (c == 0));
                end
                step();
            end
        end
    endtask

    task automatic test_drop_handoff();
        do_reset();
        req = 8'b0010_0100;
        step();
        checks++;
        if (g16 !== 8'h04 || n16 !== 1'b1) begin
            failures++; $display("FAIL drop_grant2 got gnt=%h n=%b exp gnt=04 n=1", g16, n16);
        end
        step();
        req = 8'b0010_0000;
        checks++;
        if (g16 !== 8'h04 || n16 !== 1'b0) begin
            failures++; $display("FAIL drop_cycle_t got gnt=%h n=%b exp gnt=04 n=0", g16, n16);
        end
        step();
        checks++;
        if (g16 !== 8'h20 || i16 !== 3'd5 || n16 !== 1'b1) begin
            failures++; $display("FAIL drop_t1 got gnt=%h i=%0d n=%b exp gnt=20 i=5 n=1", g16, i16, n16);
        end
    endtask

    task automatic test_sole_timeout();
        do_reset();
        req = 8'h08;
        step();
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (g3 !== 8'h08 || v3 !== 1'b1 || n3 !== ((c % 3) == 0)) begin
                failures++;
                $display("FAIL sole c=%0d got gnt=%h v=%b n=%b exp gnt=08 v=1 n=%0d", c, g3, v3, n3, ((c % 3) == 0));
            end
            step();
        end
    endtask

    task automatic test_wrap_fairness();
        do_reset();
        req = 8'h40;
        step();
        checks++;
        if (i16 !== 3'd6) begin failures++; $display("FAIL wrap_own6 got=%0d exp=6", i16); end
        req = 8'b1000_0011;
        step();
        checks++;
        if (i16 !== 3'd7 || g16 !== 8'h80 || n16 !== 1'b1) begin
            failures++; $display("FAIL wrap_own7 got i=%0d gnt=%h n=%b exp i=7 gnt=80 n=1", i16, g16, n16);
        end
        req = 8'b0000_0011;
        step();
        checks++;
        if (i16 !== 3'd0 || g16 !== 8'h01 || n16 !== 1'b1) begin
            failures++; $display("FAIL wrap_own0 got i=%0d gnt=%h n=%b exp i=0 gnt=01 n=1", i16, g16, n16);
        end
    endtask

    task automatic test_unlimited_reset();
        int bad;
        do_reset();
        req = 8'h04;
        step();
        req = 8'h10;
        step();
        checks++;
        if (g0 !== 8'h10 || n0 !== 1'b1) begin
            failures++; $display("FAIL unl_start got gnt=%h n=%b exp gnt=10 n=1", g0, n0);
        end
        req = 8'hFF;
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            checks++;
            if (g0 !== 8'h10 || n0 !== 1'b0) begin
                failures++; bad++;
                if (bad < 4) $display("FAIL unl_hold c=%0d got gnt=%h n=%b exp gnt=10 n=0", c, g0, n0);
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if (g0 !== 8'h00 || v0 !== 1'b0) begin
            failures++; $display("FAIL unl_rst got gnt=%h v=%b exp gnt=00 v=0", g0, v0);
        end
        rst = 1'b0;
        step();
        checks++;
        if (g0 !== 8'h01 || i0 !== 3'd0 || n0 !== 1'b1) begin
            failures++; $display("FAIL unl_after_rst got gnt=%h i=%0d n=%b exp gnt=01 i=0 n=1", g0, i0, n0);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_drop_handoff();
        test_sole_timeout();
        test_wrap_fairness();
        test_unlimited_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
